// File: rtl/cv32e40x_pkg.sv
// Shared types for the alignment checker: FSM states, status codes and OBI payloads.
package cv32e40x_pkg;

  typedef enum logic [1:0] {
    ALIGN_OK     = 2'd0,
    ALIGN_RE_ERR = 2'd1,
    ALIGN_WR_ERR = 2'd2
  } align_status_e;

  typedef enum logic [1:0] {
    MPU_OK       = 2'd0,
    MPU_RE_FAULT = 2'd1,
    MPU_WR_FAULT = 2'd2
  } mpu_status_e;

  typedef enum logic [1:0] {
    ALIGN_CNT_IDLE     = 2'd0,
    ALIGN_CNT_ERR_WAIT = 2'd1,
    ALIGN_CNT_ERR_RESP = 2'd2
  } align_cnt_state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [5:0]  atop;
  } obi_data_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } obi_data_resp_t;

  typedef struct packed {
    obi_data_resp_t bus_resp;
    align_status_e  align_status;
    mpu_status_e    mpu_status;
  } data_resp_t;

  // Low-address-bit mask for a log2 access size; size 3 is handled as a word.
  function automatic logic [1:0] align_mask(input logic [1:0] size);
    case (size)
      2'd0:    align_mask = 2'b00;
      2'd1:    align_mask = 2'b01;
      default: align_mask = 2'b11;
    endcase
  endfunction

endpackage

// File: rtl/cv32e40x_txn_counter.sv
// Up/down counter of in-flight bus transactions, saturating legally at MAX.
module cv32e40x_txn_counter
  import cv32e40x_pkg::*;
#(
  parameter int unsigned MAX = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       inc,
  input  logic                       dec,
  output logic [$clog2(MAX+1)-1:0]   cnt,
  output logic [$clog2(MAX+1)-1:0]   cnt_next,
  output logic                       full
);

  localparam int unsigned W = $clog2(MAX + 1);

  always_comb begin
    cnt_next = cnt;
    case ({inc, dec})
      2'b10:   cnt_next = cnt + W'(1);
      2'b01:   cnt_next = cnt - W'(1);
      default: cnt_next = cnt;
    endcase
  end

  assign full = (cnt == W'(MAX));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt <= '0;
    else     cnt <= cnt_next;
  end

  a_no_overflow:  assert property (@(posedge clk) disable iff (rst) !(inc && !dec && full));
  a_no_underflow: assert property (@(posedge clk) disable iff (rst) !(dec && !inc && (cnt == '0)));

endmodule

// File: rtl/cv32e40x_align_check_cnt.sv
// Blocks misaligned atomic/pointer transfers and answers them once earlier bus traffic drains.
// Optional err_addr_o capture is enabled by CV32E40X_ALIGN_ERR_ADDR_CAPTURE_EN.
module cv32e40x_align_check_cnt
  import cv32e40x_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter type CORE_REQ_TYPE  = obi_data_req_t,
  parameter type CORE_RESP_TYPE = data_resp_t,
  parameter type BUS_RESP_TYPE  = obi_data_resp_t
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   align_check_en_i,
  input  logic [1:0]                             core_trans_size_i,
  input  logic                                   core_align_err_wait_i,
  input  logic                                   core_trans_valid_i,
  output logic                                   core_trans_ready_o,
  input  CORE_REQ_TYPE                           core_trans_i,
  output logic                                   core_resp_valid_o,
  output CORE_RESP_TYPE                          core_resp_o,
  output logic                                   bus_trans_valid_o,
  input  logic                                   bus_trans_ready_i,
  output CORE_REQ_TYPE                           bus_trans_o,
  input  logic                                   bus_resp_valid_i,
  input  BUS_RESP_TYPE                           bus_resp_i,
  output logic                                   core_align_err_o,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding_o
`ifdef CV32E40X_ALIGN_ERR_ADDR_CAPTURE_EN
  ,
  output logic [31:0]                            err_addr_o
`endif
);

  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

  align_cnt_state_e state;
  logic             we_q;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             full;
  logic             blocked;
  logic             align_err;
  logic             err_accept;

  assign align_err        = align_check_en_i &&
                            (|(core_trans_i.addr[1:0] & align_mask(core_trans_size_i)));
  assign core_align_err_o = align_err;
  assign blocked          = full && !bus_resp_valid_i;
  assign err_accept       = (state == ALIGN_CNT_IDLE) && align_err && core_trans_valid_i;

  cv32e40x_txn_counter #(.MAX(MAX_OUTSTANDING)) u_txn_counter (
    .clk      (clk),
    .rst      (rst),
    .inc      (bus_trans_valid_o && bus_trans_ready_i),
    .dec      (bus_resp_valid_i),
    .cnt      (cnt),
    .cnt_next (cnt_next),
    .full     (full)
  );

  // Handshake steering; errored requests are swallowed, error states stall everything.
  always_comb begin
    bus_trans_valid_o  = 1'b0;
    core_trans_ready_o = 1'b0;
    if (state == ALIGN_CNT_IDLE) begin
      if (align_err) begin
        core_trans_ready_o = 1'b1;
      end else begin
        bus_trans_valid_o  = core_trans_valid_i && !blocked;
        core_trans_ready_o = bus_trans_ready_i && !blocked;
      end
    end
  end

  always_comb begin
    core_resp_o              = '0;
    core_resp_o.bus_resp     = bus_resp_i;
    core_resp_o.mpu_status   = MPU_OK;
    core_resp_o.align_status = ALIGN_OK;
    if (state == ALIGN_CNT_ERR_RESP) begin
      core_resp_o.align_status = we_q ? ALIGN_WR_ERR : ALIGN_RE_ERR;
    end
  end

  assign core_resp_valid_o = bus_resp_valid_i || (state == ALIGN_CNT_ERR_RESP);
  assign bus_trans_o       = core_trans_i;
  assign outstanding_o     = cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ALIGN_CNT_IDLE;
      we_q  <= 1'b0;
    end else begin
      case (state)
        ALIGN_CNT_IDLE: begin
          if (err_accept && core_align_err_wait_i) begin
            we_q  <= core_trans_i.we;
            state <= (cnt_next == '0) ? ALIGN_CNT_ERR_RESP : ALIGN_CNT_ERR_WAIT;
          end
        end
        ALIGN_CNT_ERR_WAIT: begin
          if (cnt_next == '0) state <= ALIGN_CNT_ERR_RESP;
        end
        default: state <= ALIGN_CNT_IDLE;
      endcase
    end
  end

`ifdef CV32E40X_ALIGN_ERR_ADDR_CAPTURE_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)             err_addr_o <= '0;
    else if (err_accept) err_addr_o <= core_trans_i.addr;
  end
`endif

  // With cnt at zero in ERR_RESP, a bus response there means a protocol violation.
  a_no_resp_in_err_resp: assert property (@(posedge clk) disable iff (rst)
    (state == ALIGN_CNT_ERR_RESP) |-> !bus_resp_valid_i);

endmodule

// File: tb/tb_cv32e40x_align_check_cnt.sv
// Self-checking bench: directed vector table, reset corner case, randomized run vs reference model.
module tb_cv32e40x_align_check_cnt;
  import cv32e40x_pkg::*;

  localparam int unsigned MAXO = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic           align_check_en;
  logic [1:0]     core_trans_size;
  logic           core_align_err_wait;
  logic           core_trans_valid;
  logic           core_trans_ready;
  obi_data_req_t  core_trans;
  logic           core_resp_valid;
  data_resp_t     core_resp;
  logic           bus_trans_valid;
  logic           bus_trans_ready;
  obi_data_req_t  bus_trans;
  logic           bus_resp_valid;
  obi_data_resp_t bus_resp;
  logic           core_align_err;
  logic [1:0]     outstanding;
`ifdef CV32E40X_ALIGN_ERR_ADDR_CAPTURE_EN
  logic [31:0]    err_addr;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cv32e40x_align_check_cnt #(.MAX_OUTSTANDING(MAXO)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .align_check_en_i      (align_check_en),
    .core_trans_size_i     (core_trans_size),
    .core_align_err_wait_i (core_align_err_wait),
    .core_trans_valid_i    (core_trans_valid),
    .core_trans_ready_o    (core_trans_ready),
    .core_trans_i          (core_trans),
    .core_resp_valid_o     (core_resp_valid),
    .core_resp_o           (core_resp),
    .bus_trans_valid_o     (bus_trans_valid),
    .bus_trans_ready_i     (bus_trans_ready),
    .bus_trans_o           (bus_trans),
    .bus_resp_valid_i      (bus_resp_valid),
    .bus_resp_i            (bus_resp),
    .core_align_err_o      (core_align_err),
    .outstanding_o         (outstanding)
`ifdef CV32E40X_ALIGN_ERR_ADDR_CAPTURE_EN
    ,
    .err_addr_o            (err_addr)
`endif
  );

  typedef struct {
    logic          valid;
    logic [31:0]   addr;
    logic [1:0]    size;
    logic          en;
    logic          wt;
    logic          we;
    logic          bready;
    logic          resp;
    logic          ebv;
    logic          erdy;
    logic          erv;
    align_status_e est;
    logic          eaerr;
    logic [1:0]    eout;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic valid, logic [31:0] addr, logic [1:0] size, logic en,
                              logic wt, logic we, logic bready, logic resp, logic ebv,
                              logic erdy, logic erv, align_status_e est, logic eaerr,
                              logic [1:0] eout);
    vec_t v;
    v.valid = valid; v.addr = addr; v.size = size; v.en = en; v.wt = wt; v.we = we;
    v.bready = bready; v.resp = resp; v.ebv = ebv; v.erdy = erdy; v.erv = erv;
    v.est = est; v.eaerr = eaerr; v.eout = eout;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Drive one cycle of inputs at the falling edge and let combinational outputs settle.
  task automatic apply(input logic valid, input logic [31:0] addr, input logic [1:0] size,
                       input logic en, input logic wt, input logic we, input logic bready,
                       input logic resp);
    @(negedge clk);
    core_trans_valid      = valid;
    core_trans            = '0;
    core_trans.addr       = addr;
    core_trans.we         = we;
    core_trans.wdata      = $urandom;
    core_trans_size       = size;
    align_check_en        = en;
    core_align_err_wait   = wt;
    bus_trans_ready       = bready;
    bus_resp_valid        = resp;
    bus_resp.rdata        = $urandom;
    bus_resp.err          = 1'($urandom);
    #1;
  endtask

  // Reference model: outstanding count plus an owed error reply that is released once drained.
  int          m_out;
  bit          m_owed;
  bit          m_due;
  bit          m_we;
  logic [31:0] m_addr;

  task automatic reset_model();
    m_out = 0; m_owed = 0; m_due = 0; m_we = 0; m_addr = 0;
  endtask

  task automatic model_cycle();
    int unsigned sz;
    bit misal, ebv, erdy, erv, issued;
    align_status_e est;
    sz    = (core_trans_size == 2'd3) ? 2 : int'(core_trans_size);
    misal = align_check_en && ((core_trans.addr % (32'd1 << sz)) != 0);
    ebv = 0; erdy = 0; erv = bus_resp_valid; est = ALIGN_OK;
    if (m_due) begin
      erv = 1; est = m_we ? ALIGN_WR_ERR : ALIGN_RE_ERR;
    end else if (!m_owed) begin
      if (misal) erdy = 1;
      else begin
        ebv  = core_trans_valid && !(m_out == MAXO && !bus_resp_valid);
        erdy = bus_trans_ready && !(m_out == MAXO && !bus_resp_valid);
      end
    end
    chk("rnd_bus_valid",  32'(bus_trans_valid),  32'(ebv));
    chk("rnd_core_ready", 32'(core_trans_ready), 32'(erdy));
    chk("rnd_resp_valid", 32'(core_resp_valid),  32'(erv));
    chk("rnd_align_err",  32'(core_align_err),   32'(misal));
    chk("rnd_outstanding", 32'(outstanding),     32'(m_out));
    if (erv) chk("rnd_align_status", 32'(core_resp.align_status), 32'(est));
    if (bus_resp_valid) chk("rnd_rdata", core_resp.bus_resp.rdata, bus_resp.rdata);
    if (ebv) chk("rnd_bus_addr", bus_trans.addr, core_trans.addr);
`ifdef CV32E40X_ALIGN_ERR_ADDR_CAPTURE_EN
    chk("rnd_err_addr", err_addr, m_addr);
`endif
    issued = ebv && bus_trans_ready;
    m_out  = m_out + int'(issued) - int'(bus_resp_valid);
    if (m_due) m_due = 0;
    else if (m_owed) begin
      if (m_out == 0) begin m_owed = 0; m_due = 1; end
    end else if (misal && core_trans_valid) begin
      m_addr = core_trans.addr;
      if (core_align_err_wait) begin
        m_we = core_trans.we;
        if (m_out == 0) m_due = 1; else m_owed = 1;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    apply(1'b0, 32'h0, 2'd2, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    core_trans_valid = 1'b0; core_trans = '0; core_trans_size = 2'd0;
    align_check_en = 1'b0; core_align_err_wait = 1'b0;
    bus_trans_ready = 1'b0; bus_resp_valid = 1'b0; bus_resp = '0;
    #12;
    chk("rst_outstanding", 32'(outstanding), 32'd0);
    chk("rst_resp_valid",  32'(core_resp_valid), 32'd0);
    chk("rst_bus_valid",   32'(bus_trans_valid), 32'd0);
`ifdef CV32E40X_ALIGN_ERR_ADDR_CAPTURE_EN
    chk("rst_err_addr", err_addr, 32'd0);
`endif
    core_trans_valid = 1'b1;
    #1;
    chk("rst_bus_valid_follows", 32'(bus_trans_valid), 32'd1);
    core_trans_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    tbl.push_back(mk(1, 32'h100, 2, 0, 1, 0, 1, 0,  1, 1, 0, ALIGN_OK,     0, 0));
    tbl.push_back(mk(1, 32'h104, 2, 0, 1, 0, 1, 0,  1, 1, 0, ALIGN_OK,     0, 1));
    tbl.push_back(mk(1, 32'h108, 2, 0, 1, 0, 1, 0,  0, 0, 0, ALIGN_OK,     0, 2));
    tbl.push_back(mk(1, 32'h108, 2, 0, 1, 0, 1, 1,  1, 1, 1, ALIGN_OK,     0, 2));
    tbl.push_back(mk(0, 32'h0,   2, 0, 1, 0, 1, 1,  0, 1, 1, ALIGN_OK,     0, 2));
    tbl.push_back(mk(0, 32'h0,   2, 0, 1, 0, 1, 1,  0, 1, 1, ALIGN_OK,     0, 1));
    tbl.push_back(mk(1, 32'h102, 2, 1, 1, 0, 1, 0,  0, 1, 0, ALIGN_OK,     1, 0));
    tbl.push_back(mk(0, 32'h0,   2, 0, 1, 0, 1, 0,  0, 0, 1, ALIGN_RE_ERR, 0, 0));
    tbl.push_back(mk(1, 32'h100, 2, 0, 1, 0, 1, 0,  1, 1, 0, ALIGN_OK,     0, 0));
    tbl.push_back(mk(1, 32'h104, 2, 0, 1, 0, 1, 0,  1, 1, 0, ALIGN_OK,     0, 1));
    tbl.push_back(mk(1, 32'h201, 1, 1, 1, 1, 1, 0,  0, 1, 0, ALIGN_OK,     1, 2));
    tbl.push_back(mk(1, 32'h300, 2, 0, 1, 0, 1, 1,  0, 0, 1, ALIGN_OK,     0, 2));
    tbl.push_back(mk(1, 32'h300, 2, 0, 1, 0, 1, 0,  0, 0, 0, ALIGN_OK,     0, 1));
    tbl.push_back(mk(1, 32'h300, 2, 0, 1, 0, 1, 1,  0, 0, 1, ALIGN_OK,     0, 1));
    tbl.push_back(mk(1, 32'h300, 2, 0, 1, 0, 1, 0,  0, 0, 1, ALIGN_WR_ERR, 0, 0));
    tbl.push_back(mk(1, 32'h400, 2, 0, 1, 0, 1, 0,  1, 1, 0, ALIGN_OK,     0, 0));
    tbl.push_back(mk(1, 32'h402, 2, 1, 1, 0, 1, 1,  0, 1, 1, ALIGN_OK,     1, 1));
    tbl.push_back(mk(0, 32'h0,   2, 0, 1, 0, 1, 0,  0, 0, 1, ALIGN_RE_ERR, 0, 0));
    tbl.push_back(mk(1, 32'h3,   1, 1, 0, 0, 1, 0,  0, 1, 0, ALIGN_OK,     1, 0));
    tbl.push_back(mk(0, 32'h0,   2, 0, 1, 0, 1, 0,  0, 1, 0, ALIGN_OK,     0, 0));
    tbl.push_back(mk(1, 32'h3,   0, 1, 1, 0, 1, 0,  1, 1, 0, ALIGN_OK,     0, 0));
    tbl.push_back(mk(0, 32'h6,   3, 1, 0, 0, 1, 1,  0, 1, 1, ALIGN_OK,     1, 1));

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i].valid, tbl[i].addr, tbl[i].size, tbl[i].en, tbl[i].wt, tbl[i].we,
            tbl[i].bready, tbl[i].resp);
      chk($sformatf("vec%0d_bus_valid", i),   32'(bus_trans_valid),  32'(tbl[i].ebv));
      chk($sformatf("vec%0d_core_ready", i),  32'(core_trans_ready), 32'(tbl[i].erdy));
      chk($sformatf("vec%0d_resp_valid", i),  32'(core_resp_valid),  32'(tbl[i].erv));
      chk($sformatf("vec%0d_align_err", i),   32'(core_align_err),   32'(tbl[i].eaerr));
      chk($sformatf("vec%0d_outstanding", i), 32'(outstanding),      32'(tbl[i].eout));
      if (tbl[i].erv) begin
        chk($sformatf("vec%0d_status", i), 32'(core_resp.align_status), 32'(tbl[i].est));
        chk($sformatf("vec%0d_mpu", i),    32'(core_resp.mpu_status),   32'(MPU_OK));
      end
`ifdef CV32E40X_ALIGN_ERR_ADDR_CAPTURE_EN
      if (i == 19) chk("vec19_err_addr", err_addr, 32'h3);
`endif
    end

    // Reset while an error reply is owed: it must be dropped.
    do_reset();
    apply(1, 32'h100, 2, 0, 1, 0, 1, 0);
    apply(1, 32'h104, 2, 0, 1, 0, 1, 0);
    apply(1, 32'h202, 2, 1, 1, 1, 1, 0);
    apply(0, 32'h0,   2, 0, 1, 0, 1, 0);
    chk("errwait_core_ready", 32'(core_trans_ready), 32'd0);
    chk("errwait_outstanding", 32'(outstanding), 32'd2);
    rst = 1'b1;
    #1;
    chk("midrst_outstanding", 32'(outstanding), 32'd0);
    chk("midrst_core_ready",  32'(core_trans_ready), 32'd1);
    chk("midrst_resp_valid",  32'(core_resp_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      apply(0, 32'h0, 2, 0, 1, 0, 1, 0);
      chk($sformatf("postrst%0d_resp_valid", i), 32'(core_resp_valid), 32'd0);
      chk($sformatf("postrst%0d_core_ready", i), 32'(core_trans_ready), 32'd1);
    end

    // Randomized traffic against the reference model.
    do_reset();
    reset_model();
    for (int i = 0; i < 3000; i++) begin
      logic r_valid, r_en, r_wt, r_we, r_bready, r_resp;
      logic [31:0] r_addr;
      logic [1:0]  r_size;
      r_valid  = ($urandom % 4) != 0;
      r_addr   = $urandom;
      r_size   = 2'($urandom);
      r_en     = ($urandom % 3) == 0;
      r_wt     = 1'($urandom);
      r_we     = 1'($urandom);
      r_bready = ($urandom % 4) != 0;
      r_resp   = (m_out > 0) && (($urandom % 3) == 0);
      apply(r_valid, r_addr, r_size, r_en, r_wt, r_we, r_bready, r_resp);
      model_cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
